// File: rtl/seg_scan_bcd.sv
`default_nettype none
// ============================================================================
// seg_scan_bcd : binary -> BCD (serial double-dabble) multiplexed 7-seg driver
// Option macro : SEG_SCAN_LZ_BLANK_EN (leading-zero blanking)
// Revision     : 1.0
// ============================================================================
module seg_scan_bcd #(
  parameter int BIN_W      = 12,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             bin_valid,
  output logic             busy,
  output logic             bcd_valid,
  output logic             overflow,
  output logic [7:0]       seg_data,
  output logic [7:0]       seg_sel
);

  // Decimal digits needed for 2^w - 1, never fewer than the displayed count.
  function automatic int calc_bcd_digits(input int w);
    longint unsigned v;
    int              n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        v = v / 64'd10;
        n = n + 1;
      end
    end
    return (n > NUM_DIGITS) ? n : NUM_DIGITS;
  endfunction

  function automatic logic [7:0] seg_font(input logic [3:0] nib);
    case (nib)
      4'd0:    return 8'b11111100;
      4'd1:    return 8'b01100000;
      4'd2:    return 8'b11011010;
      4'd3:    return 8'b11110010;
      4'd4:    return 8'b01100110;
      4'd5:    return 8'b10110110;
      4'd6:    return 8'b10111110;
      4'd7:    return 8'b11100000;
      4'd8:    return 8'b11111110;
      4'd9:    return 8'b11110110;
      default: return 8'h00;
    endcase
  endfunction

  localparam int BCD_DIGITS = calc_bcd_digits(BIN_W);
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int SR_W       = BCD_W + BIN_W;
  localparam int DISP_W     = 4 * NUM_DIGITS;
  localparam int CNT_W      = $clog2(BIN_W);
  localparam int SCAN_W     = $clog2(SCAN_DIV);

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIN_W - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [2:0]        DIG_LAST  = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]        SEG_DASH  = 8'b00000010;

`ifdef SEG_SCAN_LZ_BLANK_EN
  localparam bit LZ_BLANK = 1'b1;
`else
  localparam bit LZ_BLANK = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic                pend_q,      pend_d;
  logic [BIN_W-1:0]    pend_val_q,  pend_val_d;
  logic [SR_W-1:0]     sr_q,        sr_d;
  logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;
  logic [DISP_W-1:0]   disp_q,      disp_d;
  logic                ovf_q,       ovf_d;
  logic                bcd_valid_q, bcd_valid_d;
  logic [SCAN_W-1:0]   scan_cnt_q,  scan_cnt_d;
  logic [2:0]          dig_idx_q,   dig_idx_d;
  logic [7:0]          seg_sel_q,   seg_sel_d;
  logic [7:0]          seg_data_q,  seg_data_d;

  logic [SR_W-1:0]     sr_adj;
  logic                ovf_hi;
  logic [3:0]          cur_nib;
  logic                upper_zero;
  logic                blank;

  // Only BCD digits beyond the display width can signal overflow.
  generate
    if (BCD_DIGITS > NUM_DIGITS) begin : g_ovf
      assign ovf_hi = |sr_q[SR_W-1:BIN_W+DISP_W];
    end else begin : g_no_ovf
      assign ovf_hi = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_val_d  = pend_val_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    disp_d      = disp_q;
    ovf_d       = ovf_q;
    bcd_valid_d = 1'b0;

    sr_adj = sr_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (sr_q[BIN_W+4*i +: 4] >= 4'd5) begin
        sr_adj[BIN_W+4*i +: 4] = sr_q[BIN_W+4*i +: 4] + 4'd3;
      end
    end

    if (bin_valid && (state_q != ST_IDLE)) begin
      pend_d     = 1'b1;
      pend_val_d = bin_in;
    end

    case (state_q)
      ST_IDLE: begin
        if (bin_valid) begin
          sr_d      = {{BCD_W{1'b0}}, bin_in};
          bit_cnt_d = '0;
          pend_d    = 1'b0;
          state_d   = ST_SHIFT;
        end else if (pend_q) begin
          sr_d      = {{BCD_W{1'b0}}, pend_val_q};
          bit_cnt_d = '0;
          pend_d    = 1'b0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d      = {sr_adj[SR_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        disp_d      = sr_q[BIN_W +: DISP_W];
        ovf_d       = ovf_hi;
        bcd_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
    dig_idx_d  = dig_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      dig_idx_d = (dig_idx_q == DIG_LAST) ? 3'd0 : dig_idx_q + 3'd1;
    end

    cur_nib    = 4'd0;
    upper_zero = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx_q == 3'(i)) begin
        cur_nib    = disp_q[4*i +: 4];
        upper_zero = ((disp_q >> (4 * i)) == '0);
      end
    end
    // Digit 0 is never blanked so that zero still reads "0".
    blank = LZ_BLANK && (dig_idx_q != 3'd0) && upper_zero;

    seg_sel_d = ~(8'd1 << dig_idx_q);
    if (ovf_q) begin
      seg_data_d = SEG_DASH;
    end else if (blank) begin
      seg_data_d = 8'h00;
    end else begin
      seg_data_d = seg_font(cur_nib);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      pend_val_q  <= '0;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      disp_q      <= '0;
      ovf_q       <= 1'b0;
      bcd_valid_q <= 1'b0;
      scan_cnt_q  <= '0;
      dig_idx_q   <= 3'd0;
      seg_sel_q   <= 8'hFF;
      seg_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_val_q  <= pend_val_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      disp_q      <= disp_d;
      ovf_q       <= ovf_d;
      bcd_valid_q <= bcd_valid_d;
      scan_cnt_q  <= scan_cnt_d;
      dig_idx_q   <= dig_idx_d;
      seg_sel_q   <= seg_sel_d;
      seg_data_q  <= seg_data_d;
    end
  end

  assign busy      = (state_q != ST_IDLE) || pend_q;
  assign bcd_valid = bcd_valid_q;
  assign overflow  = ovf_q;
  assign seg_sel   = seg_sel_q;
  assign seg_data  = seg_data_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_bcd.sv
`default_nettype none
// ============================================================================
// tb_seg_scan_bcd : randomized bench for seg_scan_bcd against a decimal model
// Revision        : 1.0
// ============================================================================
module tb_seg_scan_bcd;

  localparam int BW   = 12;
  localparam int SD   = 4;
  localparam int ND_A = 4;
  localparam int ND_B = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] a_in, b_in;
  logic          a_valid, b_valid;
  logic          a_busy, a_bv, a_ovf;
  logic          b_busy, b_bv, b_ovf;
  logic [7:0]    a_seg, a_sel, b_seg, b_sel;

  int            n_vec = 0;
  int            n_err = 0;
  int            pulses;
  logic          busy_early;
  logic          busy_at2;
  logic [7:0]    font [10];

  always #5 clk = ~clk;

  seg_scan_bcd #(.BIN_W(BW), .NUM_DIGITS(ND_A), .SCAN_DIV(SD)) u_dut_a (
    .clk(clk), .rst(rst), .bin_in(a_in), .bin_valid(a_valid),
    .busy(a_busy), .bcd_valid(a_bv), .overflow(a_ovf),
    .seg_data(a_seg), .seg_sel(a_sel)
  );

  seg_scan_bcd #(.BIN_W(BW), .NUM_DIGITS(ND_B), .SCAN_DIV(SD)) u_dut_b (
    .clk(clk), .rst(rst), .bin_in(b_in), .bin_valid(b_valid),
    .busy(b_busy), .bcd_valid(b_bv), .overflow(b_ovf),
    .seg_data(b_seg), .seg_sel(b_sel)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Expected segment pattern for digit position dig of value v on an nd-digit display.
  function automatic logic [7:0] exp_seg(input int v, input int dig, input int nd);
    int p;
    p = pow10(dig);
    if (v >= pow10(nd)) return 8'b00000010;
`ifdef SEG_SCAN_LZ_BLANK_EN
    if (dig > 0 && (v / p) == 0) return 8'h00;
`endif
    return font[(v / p) % 10];
  endfunction

  function automatic logic busy_of(input bit which);
    return which ? b_busy : a_busy;
  endfunction
  function automatic logic bv_of(input bit which);
    return which ? b_bv : a_bv;
  endfunction
  function automatic logic ovf_of(input bit which);
    return which ? b_ovf : a_ovf;
  endfunction

  task automatic drive(input bit which, input logic val, input int v);
    if (which) begin
      b_valid = val;
      b_in    = BW'(v);
    end else begin
      a_valid = val;
      a_in    = BW'(v);
    end
  endtask

  task automatic tick_a();
    @(negedge clk);
    if (a_bv) pulses++;
    if (pulses < 2 && !a_busy) busy_early = 1'b1;
    if (a_bv && pulses == 2) busy_at2 = a_busy;
  endtask

  // Watch two full scan rotations and compare every slot against the model.
  task automatic check_scan(input bit which, input int v);
    int         nd, prev, run, idx;
    bit         started;
    logic [7:0] sel, dat;
    nd      = which ? ND_B : ND_A;
    prev    = -1;
    run     = 0;
    started = 1'b0;
    for (int c = 0; c < 2 * nd * SD + 2; c++) begin
      sel = which ? b_sel : a_sel;
      dat = which ? b_seg : a_seg;
      idx = -1;
      for (int i = 0; i < nd; i++) begin
        if (sel == ~(8'd1 << i)) idx = i;
      end
      check_val("sel_onehot", {31'd0, idx >= 0}, 32'd1);
      if (idx >= 0) begin
        check_val($sformatf("seg_v%0d_d%0d", v, idx), {24'd0, dat}, {24'd0, exp_seg(v, idx, nd)});
        if (idx != prev) begin
          if (prev >= 0) begin
            if (started) check_val("scan_hold", run, SD);
            check_val("scan_next", idx, (prev + 1) % nd);
            started = 1'b1;
          end
          run  = 1;
          prev = idx;
        end else begin
          run++;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic run_conv(input bit which, input int v);
    int lat, nd;
    nd = which ? ND_B : ND_A;
    drive(which, 1'b1, v);
    @(negedge clk);
    drive(which, 1'b0, 0);
    check_val("busy_cap", {31'd0, busy_of(which)}, 32'd1);
    lat = 1;
    while (!bv_of(which) && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    // Pulse lands in the cycle after capture edge + BIN_W + 1.
    check_val("latency", lat, BW + 2);
    check_val("busy_idle", {31'd0, busy_of(which)}, 32'd0);
    check_val("overflow", {31'd0, ovf_of(which)}, {31'd0, v >= pow10(nd)});
    @(negedge clk);
    check_val("bv_pulse", {31'd0, bv_of(which)}, 32'd0);
    check_scan(which, v);
  endtask

  task automatic pend_test(input int v1, input int v2, input int v3, input int g1, input int g2);
    pulses     = 0;
    busy_early = 1'b0;
    busy_at2   = 1'b1;
    drive(0, 1'b1, v1); tick_a(); drive(0, 1'b0, 0);
    repeat (g1) tick_a();
    drive(0, 1'b1, v2); tick_a(); drive(0, 1'b0, 0);
    repeat (g2) tick_a();
    drive(0, 1'b1, v3); tick_a(); drive(0, 1'b0, 0);
    repeat (2 * BW + 20) tick_a();
    check_val("pend_pulses", pulses, 2);
    check_val("pend_busy_early", {31'd0, busy_early}, 32'd0);
    check_val("pend_busy_done2", {31'd0, busy_at2}, 32'd0);
    check_val("pend_busy_end", {31'd0, a_busy}, 32'd0);
    check_scan(0, v3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    font[0] = 8'b11111100; font[1] = 8'b01100000; font[2] = 8'b11011010;
    font[3] = 8'b11110010; font[4] = 8'b01100110; font[5] = 8'b10110110;
    font[6] = 8'b10111110; font[7] = 8'b11100000; font[8] = 8'b11111110;
    font[9] = 8'b11110110;

    rst = 1'b1;
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    repeat (3) @(negedge clk);
    check_val("rst_busy", {31'd0, a_busy}, 32'd0);
    check_val("rst_bv", {31'd0, a_bv}, 32'd0);
    check_val("rst_ovf", {31'd0, a_ovf}, 32'd0);
    check_val("rst_sel", {24'd0, a_sel}, 32'hFF);
    check_val("rst_seg", {24'd0, a_seg}, 32'h00);
    check_val("rst_sel_b", {24'd0, b_sel}, 32'hFF);
    rst = 1'b0;
    @(negedge clk);

    run_conv(0, 1234);
    run_conv(1, 1000);
    run_conv(1, 999);
    run_conv(0, 7);
    run_conv(0, 0);
    run_conv(0, 4095);
    repeat (6) run_conv(0, int'($urandom_range(0, 4095)));
    repeat (4) run_conv(1, int'($urandom_range(0, 4095)));

    pend_test(100, 200, 300, 3, 3);
    repeat (4) pend_test(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                         int'($urandom_range(0, 4095)), int'($urandom_range(1, 4)),
                         int'($urandom_range(1, 4)));

    // Reset landing on the 5th SHIFT edge of a 4095 conversion.
    drive(0, 1'b1, 4095);
    @(negedge clk);
    drive(0, 1'b0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_busy", {31'd0, a_busy}, 32'd0);
    check_val("abort_sel", {24'd0, a_sel}, 32'hFF);
    check_val("abort_seg", {24'd0, a_seg}, 32'h00);
    pulses     = 0;
    busy_early = 1'b0;
    busy_at2   = 1'b1;
    repeat (30) tick_a();
    check_val("abort_no_pulse", pulses, 0);
    run_conv(0, 42);

    // New strobe coincides with the edge that would consume pending 55.
    drive(0, 1'b1, int'($urandom_range(0, 4095)));
    @(negedge clk);
    drive(0, 1'b0, 0);
    repeat (3) @(negedge clk);
    drive(0, 1'b1, 55);
    @(negedge clk);
    drive(0, 1'b0, 0);
    lat = 0;
    while (!a_bv && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check_val("sim_first_done", {31'd0, a_bv}, 32'd1);
    pulses = 0;
    drive(0, 1'b1, 66);
    tick_a();
    drive(0, 1'b0, 0);
    repeat (40) tick_a();
    check_val("sim_pulses", pulses, 1);
    check_val("sim_busy_end", {31'd0, a_busy}, 32'd0);
    check_scan(0, 66);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
